// File: rtl/uart_pkg.sv
// Shared UART encodings: parity selection and Rx sequencer states.
// Also used by the Tx sequencer.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE0 = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE1 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_t;

    function automatic logic par_enabled(input parity_t p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

endpackage

// File: rtl/rx_parity_check.sv
// Combinational parity checker for a received data word.
// Reports a mismatch only when odd or even parity is selected.
module rx_parity_check
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] data,
    input  logic                 parity_bit,
    input  parity_t              parity_type,
    output logic                 error
);

    always_comb begin
        error = 1'b0;
        unique case (parity_type)
            PAR_ODD:  error = (parity_bit != ~^data);
            PAR_EVEN: error = (parity_bit != ^data);
            default:  error = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start detect, mid-bit sampling on a
// 16x oversampling tick, parity and stop-bit checking.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 BaudTick,
    input  logic                 RxIn,
    input  logic [1:0]           ParityType,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 ParityError,
    output logic                 StopError,
    output logic                 Busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    parity_t              par_q;
    logic                 armed;
    logic                 par_err;
    logic                 at_mid;
    logic                 at_full;
    logic                 confirm;
    logic                 smp_data;
    logic                 smp_par;
    logic                 smp_stop;

    // Synchronizer resets to idle-high so reset never looks like a start bit
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxIn;
            rx_sync <= rx_meta;
        end
    end

    assign at_mid  = BaudTick && (tick_cnt == MID);
    assign at_full = BaudTick && (tick_cnt == FULL);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= RX_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        confirm   = 1'b0;
        smp_data  = 1'b0;
        smp_par   = 1'b0;
        smp_stop  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (BaudTick && armed && !rx_sync) state_nxt = RX_START;
            end
            RX_START: begin
                if (at_mid) begin
                    if (rx_sync) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        confirm   = 1'b1;
                        state_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (at_full) begin
                    smp_data = 1'b1;
                    if (bit_cnt == LAST)
                        state_nxt = par_enabled(par_q) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (at_full) begin
                    smp_par   = 1'b1;
                    state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (at_full) begin
                    smp_stop  = 1'b1;
                    state_nxt = RX_DONE;
                end
            end
            RX_DONE:  state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    rx_parity_check #(
        .DATA_BITS(DATA_BITS)
    ) u_par (
        .data       (shreg),
        .parity_bit (rx_sync),
        .parity_type(par_q),
        .error      (par_err)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_q       <= PAR_NONE0;
            armed       <= 1'b1;
            DataOut     <= '0;
            ParityError <= 1'b0;
            StopError   <= 1'b0;
        end else begin
            if (state_nxt != state || smp_data)
                tick_cnt <= '0;
            else if (BaudTick && state != RX_IDLE)
                tick_cnt <= tick_cnt + 1'b1;
            if (confirm) begin
                par_q       <= parity_t'(ParityType);
                ParityError <= 1'b0;
                StopError   <= 1'b0;
                bit_cnt     <= '0;
            end
            if (smp_data) begin
                shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (smp_par)
                ParityError <= par_err;
            // A low stop bit disarms start detection until the line is seen high
            if (smp_stop) begin
                StopError <= ~rx_sync;
                DataOut   <= shreg;
                armed     <= rx_sync;
            end else if (state == RX_IDLE && BaudTick && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign DataValid = (state == RX_DONE);
    assign Busy      = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for the UART Rx frame sequencer.
// Expected frames queue on send and are checked on each DataValid.
module tb_uart_rx_frame_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   valid_cnt;
    int   tdiv;

    uart_rx_frame_ctrl #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .Clock      (clk),
        .ResetN     (rst_n),
        .BaudTick   (baud_tick),
        .RxIn       (rx_in),
        .ParityType (parity_type),
        .DataOut    (data_out),
        .DataValid  (data_valid),
        .ParityError(parity_error),
        .StopError  (stop_error),
        .Busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One BaudTick every 4 clocks, changed on the falling edge
    initial begin
        baud_tick = 1'b0;
        tdiv      = 0;
        forever begin
            @(negedge clk);
            tdiv      = (tdiv + 1) % 4;
            baud_tick = (tdiv == 0);
        end
    end

    // Scoreboard monitor
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                valid_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got data=%h pe=%b se=%b, required no strobe",
                             data_out, parity_error, stop_error);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, parity_error, stop_error} !== {e.data, e.perr, e.serr}) begin
                        n_fail++;
                        $display("FAIL frame: got data=%h pe=%b se=%b, required data=%h pe=%b se=%b",
                                 data_out, parity_error, stop_error, e.data, e.perr, e.serr);
                    end
                end
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_at_valid: got %b, required 1", busy);
                end
            end
            if (data_valid && prev_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL valid_width: got 2+ cycle strobe, required 1 cycle");
            end
            prev_valid = data_valid;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, required finish within 5ms");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx_in = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop_bit,
                              input logic exp_perr, output logic busy_seen);
        exp_t e;
        e.data = d;
        e.perr = exp_perr;
        e.serr = ~stop_bit;
        exp_q.push_back(e);
        busy_seen = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
            if (i == 3) begin
                @(negedge clk);
                busy_seen = busy;
            end
        end
        if (use_par) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d frames pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        rx_in       = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data_out, data_valid, parity_error, stop_error, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 000",
                     {data_out, data_valid, parity_error, stop_error, busy});
        end
        rst_n = 1'b1;
        wait_ticks(20);
        @(negedge clk);
        n_tests++;
        if ({busy, data_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy/valid=%b, required 00", {busy, data_valid});
        end
    endtask

    task automatic test_even_parity();
        logic bs;
        parity_type = 2'b10;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, bs);
        n_tests++;
        if (bs !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_data: got %b, required 1", bs);
        end
        drain("even_parity");
    endtask

    task automatic test_odd_parity_error();
        logic bs;
        parity_type = 2'b01;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, bs);
        drain("odd_parity");
        @(negedge clk);
        n_tests++;
        if ({parity_error, stop_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL odd_flags_hold: got pe/se=%b, required 10", {parity_error, stop_error});
        end
    endtask

    task automatic test_false_start();
        int   vc;
        logic b_mid;
        vc = valid_cnt;
        @(negedge clk);
        rx_in = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        b_mid = busy;
        rx_in = 1'b1;
        n_tests++;
        if (b_mid !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_rise: got %b, required 1", b_mid);
        end
        wait_ticks(20);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_drop: got %b, required 0", busy);
        end
        n_tests++;
        if ({data_out, parity_error, stop_error} !== {8'h3C, 1'b1, 1'b0} || valid_cnt != vc) begin
            n_fail++;
            $display("FAIL glitch_hold: got data=%h pe=%b se=%b strobes=%0d, required 3c 1 0 %0d",
                     data_out, parity_error, stop_error, valid_cnt, vc);
        end
    endtask

    task automatic test_stop_error();
        logic bs;
        logic busy_any;
        parity_type = 2'b00;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, bs);
        drain("stop_error");
        busy_any = 1'b0;
        for (int i = 0; i < 48; i++) begin
            wait_ticks(1);
            @(negedge clk);
            busy_any |= busy;
        end
        n_tests++;
        if (busy_any !== 1'b0 || stop_error !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_rearm: got busy_seen=%b se=%b, required 0 1", busy_any, stop_error);
        end
        drive_bit(1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, bs);
        drain("after_stop_error");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic       bs;
        d = 8'h55;
        parity_type = 2'b00;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        @(negedge clk);
        rx_in = d[4];
        wait_ticks(5);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_abort: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({data_out, data_valid, parity_error, stop_error, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h, required 000",
                     {data_out, data_valid, parity_error, stop_error, busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_in = 1'b1;
        wait_ticks(20);
        parity_type = 2'b10;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, bs);
        drain("after_abort");
    endtask

    task automatic test_back_to_back();
        int   vc;
        logic bs0;
        logic bs1;
        vc = valid_cnt;
        parity_type = 2'b10;
        fork
            send_frame(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, bs0);
            begin
                wait_ticks(60);
                @(negedge clk);
                parity_type = 2'b01;
            end
        join
        send_frame(8'h34, 1'b1, 1'b0, 1'b1, 1'b0, bs1);
        drain("back_to_back");
        n_tests++;
        if (valid_cnt != vc + 2) begin
            n_fail++;
            $display("FAIL b2b_strobes: got %0d, required 2", valid_cnt - vc);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        valid_cnt = 0;
        rst_n     = 1'b0;
        rx_in     = 1'b1;
        parity_type = 2'b00;
        test_reset();
        test_even_parity();
        test_odd_parity_error();
        test_false_start();
        test_stop_error();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
